// File: rtl/pipe_pkg.sv
// Shared types and widths for the pipeline hazard/stall controller.
package pipe_pkg;

   localparam int REG_ADDR_W_DEF = 5;
   localparam int STALL_CNT_W    = 16;

   typedef enum logic {
      RUN,
      MULDIV
   } pipe_state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline-side view of the controller: hazard sources in, enables/flushes out.
interface pipe_ctrl_if
   import pipe_pkg::*;
#(
   parameter int REG_ADDR_W = REG_ADDR_W_DEF
) ();

   logic [REG_ADDR_W-1:0] id_rs1;
   logic [REG_ADDR_W-1:0] id_rs2;
   logic                  id_uses_rs1;
   logic                  id_uses_rs2;
   logic [REG_ADDR_W-1:0] ex_rd;
   logic                  ex_mem_read;
   logic                  ex_muldiv;
   logic                  ex_branch_taken;
   logic                  dmem_req;
   logic                  dmem_ready;

   logic pc_we;
   logic ifid_we;
   logic idex_we;
   logic exmem_we;
   logic memwb_we;
   logic ifid_flush;
   logic idex_flush;
   logic exmem_flush;

   modport master (
      output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd,
             ex_mem_read, ex_muldiv, ex_branch_taken, dmem_req, dmem_ready,
      input  pc_we, ifid_we, idex_we, exmem_we, memwb_we,
             ifid_flush, idex_flush, exmem_flush
   );

   modport slave (
      input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd,
             ex_mem_read, ex_muldiv, ex_branch_taken, dmem_req, dmem_ready,
      output pc_we, ifid_we, idex_we, exmem_we, memwb_we,
             ifid_flush, idex_flush, exmem_flush
   );

endinterface

// File: rtl/pipe_hazard_detect.sv
// Combinational load-use detector; x0 is never a real dependency.
module pipe_hazard_detect
   import pipe_pkg::*;
#(
   parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_uses_rs1,
   input  logic                  id_uses_rs2,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_mem_read,
   output logic                  load_use
);

   always_comb begin
      load_use = ex_mem_read && (ex_rd != '0) &&
                 ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                  (id_uses_rs2 && (id_rs2 == ex_rd)));
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: memory freeze, multi-cycle mul/div,
// taken-branch flush and load-use stall, plus a saturating stall counter.
module pipe_ctrl
   import pipe_pkg::*;
#(
   parameter int MULDIV_LAT = 4,
   parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
   input  logic                   clk,
   input  logic                   nReset,
   pipe_ctrl_if.slave             pif,
   output logic [STALL_CNT_W-1:0] stall_cycles
);

   if (MULDIV_LAT < 2) begin : g_lat_check
      $error("pipe_ctrl: MULDIV_LAT must be >= 2");
   end

   localparam int              CNT_W    = $clog2(MULDIV_LAT);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_LAT - 2);

   pipe_state_e      state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             freeze;
   logic             load_use;
   logic             pc_we, ifid_we, idex_we, exmem_we, memwb_we;
   logic             ifid_flush, idex_flush, exmem_flush;

   pipe_hazard_detect #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_hazard (
      .id_rs1      (pif.id_rs1),
      .id_rs2      (pif.id_rs2),
      .id_uses_rs1 (pif.id_uses_rs1),
      .id_uses_rs2 (pif.id_uses_rs2),
      .ex_rd       (pif.ex_rd),
      .ex_mem_read (pif.ex_mem_read),
      .load_use    (load_use)
   );

   assign freeze = pif.dmem_req && !pif.dmem_ready;

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      pc_we       = 1'b1;
      ifid_we     = 1'b1;
      idex_we     = 1'b1;
      exmem_we    = 1'b1;
      memwb_we    = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;

      if (freeze) begin
         pc_we    = 1'b0;
         ifid_we  = 1'b0;
         idex_we  = 1'b0;
         exmem_we = 1'b0;
         memwb_we = 1'b0;
      end else begin
         unique case (state)
            RUN: begin
               if (pif.ex_muldiv) begin
                  pc_we       = 1'b0;
                  ifid_we     = 1'b0;
                  idex_we     = 1'b0;
                  exmem_flush = 1'b1;
                  state_nxt   = MULDIV;
                  cnt_nxt     = CNT_LOAD;
               end else if (pif.ex_branch_taken) begin
                  ifid_flush = 1'b1;
                  idex_flush = 1'b1;
               end else if (load_use) begin
                  pc_we      = 1'b0;
                  ifid_we    = 1'b0;
                  idex_flush = 1'b1;
               end
            end
            MULDIV: begin
               if (cnt != '0) begin
                  pc_we       = 1'b0;
                  ifid_we     = 1'b0;
                  idex_we     = 1'b0;
                  exmem_flush = 1'b1;
                  cnt_nxt     = cnt - 1'b1;
               end else begin
                  state_nxt = RUN;
               end
            end
         endcase
      end

      // Reset gating sits last so it overrides every event path.
      if (!nReset) begin
         pc_we       = 1'b0;
         ifid_we     = 1'b0;
         idex_we     = 1'b0;
         exmem_we    = 1'b0;
         memwb_we    = 1'b0;
         ifid_flush  = 1'b0;
         idex_flush  = 1'b0;
         exmem_flush = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         stall_cycles <= '0;
      end else if (!pc_we && (stall_cycles != '1)) begin
         stall_cycles <= stall_cycles + 1'b1;
      end
   end

   assign pif.pc_we       = pc_we;
   assign pif.ifid_we     = ifid_we;
   assign pif.idex_we     = idex_we;
   assign pif.exmem_we    = exmem_we;
   assign pif.memwb_we    = memwb_we;
   assign pif.ifid_flush  = ifid_flush;
   assign pif.idex_flush  = idex_flush;
   assign pif.exmem_flush = exmem_flush;

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter MULDIV_LAT, default 4: total EX-stage occupancy in cycles of a multi-cycle mul/div op; SHALL be >= 2 or elaboration fails.
REQ-002 Parameter REG_ADDR_W, default 5: register-address width.
REQ-003 clk  in  1  clock; all state updates on posedge clk.
REQ-004 nReset  in  1  reset, asynchronous, active-low.
REQ-005 id_rs1, id_rs2  in  REG_ADDR_W  source registers of the instruction in ID.
REQ-006 id_uses_rs1, id_uses_rs2  in  1  ID instruction reads rs1 / rs2.
REQ-007 ex_rd  in  REG_ADDR_W  destination register of the instruction in EX.
REQ-008 ex_mem_read  in  1  EX instruction is a load.
REQ-009 ex_muldiv  in  1  EX instruction is a multi-cycle mul/div.
REQ-010 ex_branch_taken  in  1  EX resolved a taken branch or jump.
REQ-011 dmem_req, dmem_ready  in  1  MEM-stage access request / completion.
REQ-012 pc_we, ifid_we, idex_we, exmem_we, memwb_we  out  1  write enables of PC and pipeline registers.
REQ-013 ifid_flush, idex_flush, exmem_flush  out  1  load a bubble (all-zero) into that register at the next edge.
REQ-014 stall_cycles  out  16  saturating count of cycles with pc_we == 0.

Function
REQ-015 FSM states SHALL be RUN and MULDIV; a counter cnt of width clog2(MULDIV_LAT) accompanies MULDIV.
REQ-016 Default outputs, RUN with no event: all *_we = 1, all *_flush = 0.
REQ-017 Memory freeze, highest priority: dmem_req && !dmem_ready in any state -> all *_we = 0, all *_flush = 0; FSM, cnt and pending events held.
REQ-018 Mul/div entry: RUN && ex_muldiv -> pc_we = ifid_we = idex_we = 0, exmem_flush = 1, exmem_we = memwb_we = 1; next state MULDIV, cnt <= MULDIV_LAT-2.
REQ-019 MULDIV with cnt != 0: same outputs as REQ-018; cnt decrements.
REQ-020 MULDIV with cnt == 0: default outputs; next state RUN. EX occupancy is exactly MULDIV_LAT cycles with MULDIV_LAT-1 stalled cycles.
REQ-021 Taken branch (RUN, no freeze, no muldiv): pc_we = 1, ifid_flush = idex_flush = 1, other enables 1.
REQ-022 Load-use (RUN, no freeze, no muldiv, no branch): ex_mem_read && ex_rd != 0 && ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd)) -> pc_we = ifid_we = 0, idex_flush = 1, others 1; single cycle, no state change.
REQ-023 Priority: freeze > muldiv (entry or MULDIV) > branch > load-use; a lower event masked by a higher one is not remembered but re-evaluated from held inputs.
REQ-024 Whenever a *_flush is 1, the matching *_we SHALL also be 1.
REQ-025 stall_cycles SHALL increment on every clock with pc_we == 0 and saturate at 16'hFFFF.
REQ-026 All outputs except stall_cycles SHALL be combinational from state, cnt and inputs; zero added latency.

Reset
REQ-027 nReset low -> state = RUN, cnt = 0, stall_cycles = 0 immediately; all *_we and *_flush forced to 0 while nReset is low.
REQ-028 Reset asserted during MULDIV or a freeze SHALL abort it; the first cycle after release is RUN.

Structure
REQ-029 A shared package pipe_pkg SHALL hold the state enum (RUN, MULDIV), REG_ADDR_W default and the stall-counter width.
REQ-030 Load-use comparison SHALL be a combinational sub-module pipe_hazard_detect (inputs per REQ-005..008, output load_use).

Verification
REQ-031 Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 -> one cycle pc_we=0, ifid_we=0, idex_flush=1; next cycle defaults; stall_cycles +1.
REQ-032 x0 exclusion: same as REQ-031 with ex_rd=0, id_rs1=0 -> no stall.
REQ-033 Mul/div, MULDIV_LAT=4: ex_muldiv high in cycle 0 -> pc_we=0 in cycles 0-2, pc_we=1 in cycle 3, state RUN in cycle 4; stall_cycles +3.
REQ-034 Freeze inside mul/div: dmem_req=1, dmem_ready=0 for 2 cycles at MULDIV cnt=1 -> all we=0 those cycles, cnt stays 1, mul/div finishes 2 cycles later.
REQ-035 Branch during freeze: ex_branch_taken=1 with freeze 1 cycle -> no flush in that cycle; next cycle ifid_flush=idex_flush=1, pc_we=1.
REQ-036 Reset mid-MULDIV and saturation: nReset low at cnt=1 -> outputs 0, state RUN after release; stall_cycles preloaded to 16'hFFFE, 3 stalled cycles -> 16'hFFFF.
